i2c_slave_regs: RTL and testbench
=================================

// Module: i2c_slave_regs
// PURPOSE
//  I2C target (responder) with a small byte-wide register file, the slave counterpart of our i2c_master.
//  Used as a board-level sensor emulator on an SDA/SCL channel and as a loopback target for bench and bring-up.
//  Protocol: 7-bit address, one pointer byte, then data bytes; pointer auto-increments; repeated START supported.
// PARAMETERS
//  BASE_ADR  7'b1001000  upper 4 bits of the target address; low 3 bits come from DEV_ADR
//  PTR_W     2           pointer width; register file holds 2**PTR_W bytes; pointer wraps modulo 2**PTR_W
// PORTS
//  CLK        in   1  system clock, at least 16x SCL
//  RES_N      in   1  asynchronous active-low reset
//  SCL_IN     in   1  SCL from pad, asynchronous
//  SDA_IN     in   1  SDA from pad, asynchronous
//  SDA_OE     out  1  1 = pull SDA low (open drain); the IOBUFE input is tied to 0
//  DEV_ADR    in   3  low address bits (strap pins)
//  TEMP_IN    in   8  live value returned for register 0 (read-only from I2C)
//  WR_STB     out  1  one-CLK pulse for each data byte written over I2C
//  WR_ADR     out  PTR_W  register index of the last write
//  WR_DATA    out  8  data of the last write
//  BUSY       out  1  high from an address match until STOP
// BEHAVIOUR
//  - Reset: SDA_OE=0, WR_STB=0, WR_ADR=0, WR_DATA=0, BUSY=0, pointer=0, register file all 0, state IDLE.
//  - Reset is asynchronous: SDA_OE releases in the same cycle RES_N falls, including mid-transfer.
//  - Inputs pass through a 2-FF synchroniser. Edges are taken on the synchronised signals.
//    Latency from pad to edge detect is 3 CLK.
//  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
//    Both take priority over bit sampling in the same cycle.
//  - START from any state goes to ADDR and clears the bit counter (repeated START included).
//    STOP from any state goes to IDLE, sets SDA_OE=0 and clears BUSY.
//  - Data is sampled on SCL rising edges. SDA_OE changes only on SCL falling edges, one CLK after detection.
//  - States and transitions:
//    IDLE -> ADDR (on START).
//    ADDR: shift 8 bits.
//      If addr=={BASE_ADR[6:3],DEV_ADR}: ACK_A.
//      Otherwise: IDLE, SDA_OE is never asserted.
//    ACK_A: drive SDA_OE=1 for one SCL low/high period. Set BUSY.
//      R/W=0 -> PTR. R/W=1 -> RD.
//    PTR: 8 bits; pointer <= byte[PTR_W-1:0] (upper bits ignored). Then ACK_P, then WR.
//    WR: 8 bits. Write reg[pointer]; a write to index 0 is ignored but still ACKed.
//      Pulse WR_STB; load WR_ADR/WR_DATA. Then ACK_W; pointer+1 with wrap; back to WR.
//    RD: on the SCL falling edge after the ACK (or after the previous byte), load the shift register.
//      Source is TEMP_IN if pointer==0, else reg[pointer].
//      Drive SDA_OE = ~bit, MSB first. After 8 bits release SDA -> MACK.
//    MACK: sample SDA on SCL rising.
//      0 (ACK): pointer+1 with wrap -> RD.
//      1 (NACK): go to WAIT, keep SDA released until STOP or START.
//  - Bit counter is 3 bits and counts 0..7. The 9th clock is handled by the ACK/MACK states.
//  - An incomplete byte aborted by START/STOP leaves the register file and pointer unchanged.
// CONFIGURATION
//  I2C_SLV_FILTER_EN defined: a 3-sample majority filter follows the synchroniser on SCL and SDA.
//    Pulses of 1 CLK are rejected. Pad-to-edge latency becomes 5 CLK.
//  Not defined: synchroniser only; a 1-CLK glitch is seen as a real edge.
// STRUCTURE
//  Package i2c_pkg: state encoding (IDLE, ADDR, ACK_A, PTR, ACK_P, WR, ACK_W, RD, MACK, WAIT).
//    Also I2C_ACK=1'b0, I2C_NACK=1'b1, default BASE_ADR constant.
//  Sub-module i2c_line_sync: synchroniser, optional filter, and rise/fall/START/STOP pulses for both lines.
//  The top holds the FSM, shift register, pointer and register file.
// TESTING
//  - Write: DEV_ADR=0. START,0x90,0x02,0x5A,STOP.
//    -> three ACKs, reg[2]=0x5A, one WR_STB with WR_ADR=2, WR_DATA=0x5A, BUSY low after STOP.
//  - Read with repeated START: TEMP_IN=0x19. START,0x90,0x00,Sr,0x91, read 2 bytes (ACK then NACK), STOP.
//    -> bytes 0x19 then reg[1]; SDA released after the NACK.
//  - Address miss: START,0x92 with DEV_ADR=0. -> SDA_OE stays 0 for the whole frame, BUSY stays 0.
//  - Wrap: pointer=3, PTR_W=2. Read 2 bytes. -> reg[3], then TEMP_IN (index 0).
//  - Abort: STOP after 4 bits of a WR byte. -> no WR_STB, register unchanged, state IDLE.
//    RES_N low mid-RD while a 0 bit is being driven -> SDA_OE=0 in the same cycle.
//  - Filter: 1-CLK SCL high glitch during a data byte.
//    With I2C_SLV_FILTER_EN: the byte is received correctly.
//    Without it: an extra bit is shifted in (check the misalignment).

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the i2c_slave_regs register-file target:
//   - i2c_state_e : FSM state encoding of the target
//   - I2C_ACK / I2C_NACK : SDA level of an acknowledge / not-acknowledge bit
//   - I2C_BASE_ADR : default 7-bit base address (low 3 bits replaced by straps)
//   - maj3() : 2-of-3 majority vote used by the optional line filter
// Configuration macro: I2C_SLV_FILTER_EN (consumed by i2c_line_sync).
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_A,
        PTR,
        ACK_P,
        WR,
        ACK_W,
        RD,
        MACK,
        WAIT
    } i2c_state_e;

    localparam logic       I2C_ACK      = 1'b0;
    localparam logic       I2C_NACK     = 1'b1;
    localparam logic [6:0] I2C_BASE_ADR = 7'b1001000;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// -----------------------------------------------------------------------------
// i2c_line_sync
// Brings the asynchronous SCL/SDA pad inputs into the CLK domain and derives
// single-cycle event pulses from them.
// Ports:
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   scl_i, sda_i         raw pad levels
//   sda_o                conditioned SDA level (for bit sampling)
//   scl_rise_o/fall_o    one-CLK pulses on conditioned SCL edges
//   start_o / stop_o     one-CLK pulses: SDA falls / rises while SCL is high
// Configuration macro: I2C_SLV_FILTER_EN adds a 3-sample majority filter
// behind the synchroniser (rejects 1-CLK pulses, pad-to-edge latency 5 CLK
// instead of 3).
// -----------------------------------------------------------------------------
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_lvl, sda_lvl;
    logic       sda_rise, sda_fall;

    // Reset to 1 (idle bus) so that leaving reset never fakes an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

`ifdef I2C_SLV_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
        end
    end

    // Combinational vote: a level needs two of the last three samples.
    assign scl_lvl = maj3(scl_hist_q);
    assign sda_lvl = maj3(sda_hist_q);
`else
    assign scl_lvl = scl_sync_q[1];
    assign sda_lvl = sda_sync_q[1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_lvl;
            sda_prev_q <= sda_lvl;
        end
    end

    assign sda_rise   =  sda_lvl & ~sda_prev_q;
    assign sda_fall   = ~sda_lvl &  sda_prev_q;
    assign scl_rise_o =  scl_lvl & ~scl_prev_q;
    assign scl_fall_o = ~scl_lvl &  scl_prev_q;
    assign start_o    = sda_fall & scl_lvl;
    assign stop_o     = sda_rise & scl_lvl;
    assign sda_o      = sda_lvl;

endmodule

// File: rtl/i2c_slave_regs.sv
// -----------------------------------------------------------------------------
// i2c_slave_regs
// I2C target with a byte-wide register file of 2**PTR_W entries. Frame format:
// address byte, pointer byte, data bytes (pointer auto-increments with wrap).
// Register 0 reads the live TEMP_IN value and ignores writes.
// Ports:
//   CLK, RES_N      system clock (>= 16x SCL), asynchronous active-low reset
//   SCL_IN, SDA_IN  asynchronous pad inputs
//   SDA_OE          1 = pull SDA low (open drain)
//   DEV_ADR         strap bits forming the low 3 address bits
//   TEMP_IN         value returned for register 0
//   WR_STB          one-CLK pulse per data byte written over I2C
//   WR_ADR/WR_DATA  index and data of the last write
//   BUSY            high from an address match until STOP
// Configuration macro: I2C_SLV_FILTER_EN (line glitch filter, see
// i2c_line_sync).
// -----------------------------------------------------------------------------
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] BASE_ADR = I2C_BASE_ADR,
    parameter int         PTR_W    = 2
) (
    input  logic             CLK,
    input  logic             RES_N,
    input  logic             SCL_IN,
    input  logic             SDA_IN,
    output logic             SDA_OE,
    input  logic [2:0]       DEV_ADR,
    input  logic [7:0]       TEMP_IN,
    output logic             WR_STB,
    output logic [PTR_W-1:0] WR_ADR,
    output logic [7:0]       WR_DATA,
    output logic             BUSY
);

    localparam int NREG = 2 ** PTR_W;

    logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;

    i2c_line_sync u_sync (
        .clk_i      (CLK),
        .rst_ni     (RES_N),
        .scl_i      (SCL_IN),
        .sda_i      (SDA_IN),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_ev),
        .stop_o     (stop_ev)
    );

    i2c_state_e       state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       sr_q, sr_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       regs_q [NREG];
    logic [7:0]       regs_d [NREG];
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_stb_q, wr_stb_d;
    logic [PTR_W-1:0] wr_adr_q, wr_adr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             rd_load_q, rd_load_d;  // next SCL fall loads a read byte

    logic [6:0] own_adr;
    logic [7:0] byte_c;  // byte completed by the bit being sampled now
    logic [7:0] rd_src;

    assign own_adr = {BASE_ADR[6:3], DEV_ADR};
    assign byte_c  = {sr_q[6:0], sda_s};
    assign rd_src  = (ptr_q == '0) ? TEMP_IN : regs_q[ptr_q];

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            sr_q      <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_adr_q  <= '0;
            wr_data_q <= '0;
            rd_load_q <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            sr_q      <= sr_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_adr_q  <= wr_adr_d;
            wr_data_q <= wr_data_d;
            rd_load_q <= rd_load_d;
            regs_q    <= regs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        regs_d    = regs_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;
        rd_load_d = rd_load_q;

        // Bus conditions override any bit activity in the same cycle.
        if (stop_ev) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            rd_load_d = 1'b0;
        end else if (start_ev) begin
            state_d   = ADDR;
            bitcnt_d  = '0;
            sda_oe_d  = 1'b0;
            rd_load_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, WAIT: ;

                ADDR: if (scl_rise) begin
                    sr_d     = byte_c;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (byte_c[7:1] == own_adr) begin
                            state_d = ACK_A;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end

                PTR: if (scl_rise) begin
                    sr_d     = byte_c;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        ptr_d   = byte_c[PTR_W-1:0];
                        state_d = ACK_P;
                    end
                end

                WR: if (scl_rise) begin
                    sr_d     = byte_c;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (ptr_q != '0) regs_d[ptr_q] = byte_c;
                        wr_stb_d  = 1'b1;
                        wr_adr_d  = ptr_q;
                        wr_data_d = byte_c;
                        ptr_d     = ptr_q + PTR_W'(1);
                        state_d   = ACK_W;
                    end
                end

                // OE is always released on entry, so its level marks which
                // falling edge this is: the first starts the ACK, the second
                // ends it.
                ACK_A, ACK_P, ACK_W: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = '0;
                        if (state_q == ACK_A && sr_q[0]) begin
                            state_d  = RD;
                            sr_d     = rd_src;
                            sda_oe_d = ~rd_src[7];
                        end else if (state_q == ACK_A) begin
                            state_d = PTR;
                        end else begin
                            state_d = WR;
                        end
                    end
                end

                RD: if (scl_fall) begin
                    if (rd_load_q) begin
                        rd_load_d = 1'b0;
                        sr_d      = rd_src;
                        sda_oe_d  = ~rd_src[7];
                        bitcnt_d  = '0;
                    end else if (bitcnt_q == 3'd7) begin
                        sda_oe_d = 1'b0;
                        state_d  = MACK;
                    end else begin
                        sr_d     = {sr_q[6:0], 1'b0};
                        sda_oe_d = ~sr_q[6];
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end

                MACK: if (scl_rise) begin
                    if (sda_s == I2C_ACK) begin
                        ptr_d     = ptr_q + PTR_W'(1);
                        rd_load_d = 1'b1;
                        state_d   = RD;
                    end else begin
                        state_d = WAIT;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    assign SDA_OE  = sda_oe_q;
    assign BUSY    = busy_q;
    assign WR_STB  = wr_stb_q;
    assign WR_ADR  = wr_adr_q;
    assign WR_DATA = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_regs
// Directed bench for i2c_slave_regs: a bit-banged I2C master drives the pads,
// expected write strobes and read bytes go through scoreboard queues.
// Honours I2C_SLV_FILTER_EN when choosing glitch-test expectations.
// -----------------------------------------------------------------------------
module tb_i2c_slave_regs;

    localparam int Q = 8;  // quarter SCL period in CLK cycles

    logic       CLK = 1'b0;
    logic       RES_N;
    logic       scl_m, sda_m;
    logic       SDA_OE;
    logic [2:0] DEV_ADR;
    logic [7:0] TEMP_IN;
    logic       WR_STB;
    logic [1:0] WR_ADR;
    logic [7:0] WR_DATA;
    logic       BUSY;
    logic       sda_bus;

    int errors = 0;
    int checks = 0;

    logic [9:0] wr_q [$];  // {adr, data}
    logic [7:0] rd_q [$];
    logic       oe_seen, busy_seen;

    assign sda_bus = sda_m & ~SDA_OE;

    always #5 CLK = ~CLK;

    i2c_slave_regs dut (
        .CLK     (CLK),
        .RES_N   (RES_N),
        .SCL_IN  (scl_m),
        .SDA_IN  (sda_bus),
        .SDA_OE  (SDA_OE),
        .DEV_ADR (DEV_ADR),
        .TEMP_IN (TEMP_IN),
        .WR_STB  (WR_STB),
        .WR_ADR  (WR_ADR),
        .WR_DATA (WR_DATA),
        .BUSY    (BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write-strobe scoreboard and line activity monitors.
    always @(negedge CLK) begin
        if (SDA_OE) oe_seen = 1'b1;
        if (BUSY)   busy_seen = 1'b1;
        if (RES_N === 1'b1 && WR_STB === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", {22'd0, WR_ADR, WR_DATA}, 32'hFFFF_FFFF);
            end else begin
                logic [9:0] e;
                e = wr_q.pop_front();
                chk("wr_adr", WR_ADR, e[9:8]);
                chk("wr_data", WR_DATA, e[7:0]);
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bit_io(input logic b, output logic seen);
        wclk(Q); sda_m = b;
        wclk(Q); scl_m = 1'b1;
        wclk(Q); seen = sda_bus;
        wclk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wclk(Q); sda_m = 1'b0;
        wclk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        wclk(Q); sda_m = 1'b1;
        wclk(Q); scl_m = 1'b1;
        wclk(Q); sda_m = 1'b0;
        wclk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(Q); sda_m = 1'b0;
        wclk(Q); scl_m = 1'b1;
        wclk(Q); sda_m = 1'b1;
        wclk(2 * Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(d[i], s);
        bit_io(1'b1, ack);
    endtask

    task automatic rbyte(input logic mack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_io(1'b1, s);
            d = {d[6:0], s};
        end
        bit_io(mack, s);
    endtask

    task automatic rd_chk(input string tag, input logic mack);
        logic [7:0] d, e;
        rbyte(mack, d);
        e = rd_q.pop_front();
        chk(tag, d, e);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] gbyte;

        RES_N = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        DEV_ADR = 3'd0; TEMP_IN = 8'h19;
        oe_seen = 1'b0; busy_seen = 1'b0;
        wclk(5);
        chk("rst_oe", SDA_OE, 0);
        chk("rst_stb", WR_STB, 0);
        chk("rst_adr", WR_ADR, 0);
        chk("rst_data", WR_DATA, 0);
        chk("rst_busy", BUSY, 0);
        RES_N = 1'b1;
        wclk(4);

        // Single write to reg 2.
        i2c_start();
        wbyte(8'h90, ack); chk("t1_ack_a", ack, 0);
        chk("t1_busy", BUSY, 1);
        wbyte(8'h02, ack); chk("t1_ack_p", ack, 0);
        wr_q.push_back({2'd2, 8'h5A});
        wbyte(8'h5A, ack); chk("t1_ack_w", ack, 0);
        i2c_stop();
        chk("t1_busy_end", BUSY, 0);
        chk("t1_wr_adr", WR_ADR, 2);
        chk("t1_wr_data", WR_DATA, 8'h5A);

        // Two-byte write, pointer auto-increment.
        i2c_start();
        wbyte(8'h90, ack); chk("t2_ack_a", ack, 0);
        wbyte(8'h01, ack); chk("t2_ack_p", ack, 0);
        wr_q.push_back({2'd1, 8'hA5});
        wbyte(8'hA5, ack); chk("t2_ack_w0", ack, 0);
        wr_q.push_back({2'd2, 8'h3C});
        wbyte(8'h3C, ack); chk("t2_ack_w1", ack, 0);
        i2c_stop();

        // Write wrapping from reg 3 onto read-only reg 0.
        i2c_start();
        wbyte(8'h90, ack);
        wbyte(8'h03, ack);
        wr_q.push_back({2'd3, 8'h77});
        wbyte(8'h77, ack); chk("t3_ack_w0", ack, 0);
        wr_q.push_back({2'd0, 8'h11});
        wbyte(8'h11, ack); chk("t3_ack_w1", ack, 0);
        i2c_stop();

        // Read with repeated START: TEMP_IN then reg 1.
        i2c_start();
        wbyte(8'h90, ack);
        wbyte(8'h00, ack);
        i2c_rstart();
        wbyte(8'h91, ack); chk("t4_ack_a", ack, 0);
        rd_q.push_back(8'h19); rd_chk("t4_rd0", 1'b0);
        rd_q.push_back(8'hA5); rd_chk("t4_rd1", 1'b1);
        wclk(Q);
        chk("t4_released", SDA_OE, 0);
        i2c_stop();

        // Read wrapping from reg 3 to reg 0 (live TEMP_IN).
        TEMP_IN = 8'h42;
        i2c_start();
        wbyte(8'h90, ack);
        wbyte(8'h03, ack);
        i2c_rstart();
        wbyte(8'h91, ack);
        rd_q.push_back(8'h77); rd_chk("t5_rd3", 1'b0);
        rd_q.push_back(8'h42); rd_chk("t5_rd0", 1'b1);
        i2c_stop();

        // Address miss.
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        wbyte(8'h92, ack); chk("t6_nack", ack, 1);
        wbyte(8'h00, ack);
        i2c_stop();
        chk("t6_oe_never", oe_seen, 0);
        chk("t6_busy_never", busy_seen, 0);

        // Abort a data byte after 4 bits; register and pointer unchanged.
        i2c_start();
        wbyte(8'h90, ack);
        wbyte(8'h02, ack);
        for (int i = 0; i < 4; i++) bit_io(1'b1, s);
        i2c_stop();
        chk("t7_busy", BUSY, 0);
        i2c_start();
        wbyte(8'h91, ack); chk("t7_ack_a", ack, 0);
        rd_q.push_back(8'h3C); rd_chk("t7_rd2", 1'b1);
        i2c_stop();

        // 1-CLK SCL glitch inside a data byte 0xA5 written to reg 1.
        i2c_start();
        wbyte(8'h90, ack);
        wbyte(8'h01, ack);
`ifdef I2C_SLV_FILTER_EN
        wr_q.push_back({2'd1, 8'hA5});
`else
        wr_q.push_back({2'd1, 8'hA2});
`endif
        gbyte = 8'hA5;
        for (int i = 7; i >= 4; i--) bit_io(gbyte[i], s);
        wclk(Q);
        scl_m = 1'b1; wclk(1); scl_m = 1'b0;
        for (int i = 3; i >= 0; i--) bit_io(gbyte[i], s);
        bit_io(1'b1, ack);
`ifdef I2C_SLV_FILTER_EN
        chk("t8_ack", ack, 0);
`else
        chk("t8_ack", ack, 1);
`endif
        i2c_stop();

        // Asynchronous reset while a 0 bit is driven in a read.
        TEMP_IN = 8'h00;
        i2c_start();
        wbyte(8'h90, ack);
        wbyte(8'h00, ack);
        i2c_rstart();
        wbyte(8'h91, ack);
        wclk(Q);
        chk("t9_driving", SDA_OE, 1);
        #1 RES_N = 1'b0;
        #1 chk("t9_async_oe", SDA_OE, 0);
        chk("t9_busy", BUSY, 0);
        wclk(3);
        RES_N = 1'b1;
        wclk(Q);
        scl_m = 1'b1; sda_m = 1'b1;
        wclk(2 * Q);
        i2c_start();
        wbyte(8'h90, ack);
        wbyte(8'h01, ack);
        i2c_rstart();
        wbyte(8'h91, ack); chk("t9_ack_a", ack, 0);
        rd_q.push_back(8'h00); rd_chk("t9_rd1_cleared", 1'b1);
        i2c_stop();

        wclk(4);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
